// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instruction, pc} entries.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC register, FETCH/FAULT state machine,
// redirect handling and the decode-facing fetch buffer.
// Optional build macro: FETCH_STATS_EN adds push/stall/flush counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | fetching sequentially, pushing into the buffer when room
// FAULT | halted after a misaligned redirect, waiting for aligned redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] read_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        misaligned_fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_flush
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         push;
    logic         pop;
    logic         flush;
    logic         stall;
    logic         fifo_full;
    logic         fifo_empty;
    logic         target_aligned;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign target_aligned   = (redirect_target[1:0] == 2'b00);
    assign read_address     = pc_q;
    assign push_entry.instr = instruction;
    assign push_entry.pc    = pc_q;
    // Head fields read as zero whenever nothing valid is presented.
    assign out_instruction  = out_valid ? head.instr : 32'h0;
    assign out_pc           = out_valid ? head.pc    : 32'h0;

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and buffer controls; redirect beats push and pop.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        push             = 1'b0;
        pop              = 1'b0;
        flush            = 1'b0;
        stall            = 1'b0;
        out_valid        = 1'b0;
        misaligned_fault = 1'b0;
        case (state_q)
            FETCH: begin
                out_valid = !fifo_empty;
                if (redirect_valid) begin
                    // Decode's pop this cycle is squashed by execute, so ignore it.
                    flush = 1'b1;
                    if (target_aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    pop   = out_valid && out_ready;
                    push  = !fifo_full || pop;
                    stall = fifo_full && !pop;
                    if (push) begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            FAULT: begin
                misaligned_fault = 1'b1;
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (target_aligned) begin
                        pc_d    = redirect_target;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

`ifdef FETCH_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= 32'h0;
            stat_stall   <= 32'h0;
            stat_flush   <= 32'h0;
        end else begin
            if (push && (stat_fetched != 32'hFFFF_FFFF)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (stall && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (redirect_valid && (stat_flush != 32'hFFFF_FFFF)) begin
                stat_flush <= stat_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a scoreboard of expected head entries.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        misaligned_fault;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
    logic [31:0] stat_flush;
`endif

    int checks = 0;
    int errors = 0;
    fetch_entry_t sb[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign instruction = mem_word(read_address);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .read_address     (read_address),
        .instruction      (instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .misaligned_fault (misaligned_fault)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched     (stat_fetched),
        .stat_stall       (stat_stall),
        .stat_flush       (stat_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // Compare any pop happening in the current cycle, then advance one clock.
    task automatic cycle();
        fetch_entry_t e;
        if (!reset && !redirect_valid && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_pop: observed pc %h expected no entry", out_pc);
            end else begin
                e = sb.pop_front();
                chk("head_pc", out_pc, e.pc);
                chk("head_instr", out_instruction, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        out_ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_valid", out_valid, 1'b0);
        chk("rst_fault", misaligned_fault, 1'b0);
        chk("rst_raddr", read_address, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instruction, 32'h0);

        // Streaming after reset release.
        reset = 1'b0;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        expect_pc(32'hC);
        for (int i = 0; i < 5; i++) begin
            chk("stream_valid", out_valid, (i > 0) ? 1'b1 : 1'b0);
            cycle();
        end
        chk("stream_drained", sb.size(), 0);

        // Backpressure from the start.
        reset     = 1'b1;
        out_ready = 1'b0;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                chk("bp_raddr", read_address, 32'h8);
                chk("bp_valid", out_valid, 1'b1);
                chk("bp_out_pc", out_pc, 32'h0);
                chk("bp_out_instr", out_instruction, mem_word(32'h0));
            end
            cycle();
        end
        chk("bp_raddr_end", read_address, 32'h8);
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("bp_drained", sb.size(), 0);

        // Redirect while buffer full.
        chk("full_valid", out_valid, 1'b1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_valid_n1", out_valid, 1'b0);
        chk("redir_raddr_n1", read_address, 32'h40);
        expect_pc(32'h40);
        cycle();
        chk("redir_valid_n2", out_valid, 1'b1);
        chk("redir_pc_n2", out_pc, 32'h40);
        cycle();
        chk("redir_drained", sb.size(), 0);
        chk("pre_fault_raddr", read_address, 32'h48);

        // Misaligned redirect, stay in fault, then recover.
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        cycle();
        redirect_valid = 1'b0;
        chk("fault_flag", misaligned_fault, 1'b1);
        chk("fault_valid", out_valid, 1'b0);
        chk("fault_raddr", read_address, 32'h48);
        cycle();
        chk("fault_hold_flag", misaligned_fault, 1'b1);
        chk("fault_hold_raddr", read_address, 32'h48);
        redirect_valid  = 1'b1;
        redirect_target = 32'h43;
        cycle();
        redirect_valid = 1'b0;
        chk("fault_again_flag", misaligned_fault, 1'b1);
        chk("fault_again_valid", out_valid, 1'b0);
        chk("fault_again_raddr", read_address, 32'h48);
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        cycle();
        redirect_valid = 1'b0;
        chk("recover_flag", misaligned_fault, 1'b0);
        chk("recover_valid", out_valid, 1'b0);
        chk("recover_raddr", read_address, 32'h80);
        expect_pc(32'h80);
        cycle();
        chk("recover_head_valid", out_valid, 1'b1);
        chk("recover_head_pc", out_pc, 32'h80);
        cycle();
        chk("recover_drained", sb.size(), 0);

        // PC wrap-around.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        chk("wrap_valid_n1", out_valid, 1'b0);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0);
        repeat (3) cycle();
        chk("wrap_drained", sb.size(), 0);

        // Reset while the buffer is full.
        out_ready = 1'b0;
        repeat (2) cycle();
        chk("prereset_valid", out_valid, 1'b1);
        chk("prereset_out_pc", out_pc, 32'h4);
        chk("prereset_raddr", read_address, 32'hC);
        reset = 1'b1;
        cycle();
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_raddr", read_address, 32'h0);
        chk("midrst_out_pc", out_pc, 32'h0);
        chk("midrst_out_instr", out_instruction, 32'h0);
        chk("midrst_fault", misaligned_fault, 1'b0);
        reset = 1'b0;

`ifdef FETCH_STATS_EN
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            expect_pc(32'(i * 4));
        end
        repeat (10) cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        chk("stat_fetched", stat_fetched, 32'd10);
        chk("stat_flush", stat_flush, 32'd1);
        chk("stat_stall", stat_stall, 32'd0);
        chk("stats_drained", sb.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Owns the program counter and drives the word-aligned `read_address` of the instruction memory, which returns the `instruction` combinationally in the same cycle. It captures each returned word with its PC into a 2-entry buffer and presents the buffer to decode through a valid/ready handshake. It also accepts PC redirects from execute for branches and jumps.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be 4-byte aligned.
- `DEPTH`, default `2`: fetch buffer entries; legal values 2 or 4.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `read_address`  out  32  word address to instruction memory; equals the current PC.
- `instruction`  in  32  word returned by instruction memory in the same cycle.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_target`  in  32  new PC.
- `out_valid`  out  1  buffer head holds a valid fetched instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instruction`  out  32  head instruction word.
- `out_pc`  out  32  PC of the head instruction.
- `misaligned_fault`  out  1  unit halted on a redirect target with `[1:0] != 2'b00`.

## Operation
- State machine in `fetch_pkg::fetch_state_t`:
  - FETCH: normal fetching.
  - FAULT: halted after a misaligned redirect.
- FETCH:
  - A push occurs when the buffer is not full, or when it is full and a pop happens in the same cycle.
  - Push writes `{instruction, pc}` at the tail and sets `pc <= pc + 4` (32-bit modular; `32'hFFFF_FFFC` wraps to `0`).
  - With no push, `pc` and `read_address` hold.
- Pop occurs on `out_valid && out_ready`. Buffer order is strictly FIFO: no duplicated or lost entries.
- Redirect has priority over push and pop in the same cycle:
  - The buffer is flushed and the push is squashed.
  - A pop by decode in that cycle is ignored by this unit, because execute squashes it.
  - Aligned target: `pc <= redirect_target` and the state stays FETCH.
  - Misaligned target: `pc` is unchanged and the state goes to FAULT.
- FAULT:
  - No pushes; `out_valid = 0`; `misaligned_fault = 1`.
  - An aligned redirect flushes the buffer, loads the target and returns to FETCH.
  - A misaligned redirect keeps the unit in FAULT.
- Reset applies in any state, including mid-flush or while full:
  - `pc = RESET_PC`, buffer empty, state FETCH.
  - `out_valid = 0`, `misaligned_fault = 0`, `out_instruction = 0`, `out_pc = 0`.
  - `read_address = RESET_PC`.

## Timing
- `read_address` is registered: it is the `pc` register itself.
- Fetch-to-decode latency is 1 cycle. An instruction pushed in cycle N is at the head in cycle N+1 if the buffer was empty.
- Sustained throughput is 1 instruction per cycle with `out_ready = 1`.
- Redirect in cycle N:
  - `out_valid = 0` in cycle N+1.
  - The target is fetched in cycle N+1.
  - The target's instruction is at the head in cycle N+2.
- `misaligned_fault` rises in the cycle after the offending redirect.
- While FETCH and the buffer is full with no pop, the unit holds off: no pushes and `pc` unchanged.
- `out_*` values are stable while `out_valid && !out_ready`.

## Configuration
- `FETCH_STATS_EN` defined:
  - Adds outputs `stat_fetched[31:0]`, which counts pushes.
  - Adds `stat_stall[31:0]`, which counts FETCH cycles where the buffer is full with no pop.
  - Adds `stat_flush[31:0]`, which counts redirects.
  - All counters reset to 0 and saturate at `32'hFFFF_FFFF`.
- `FETCH_STATS_EN` undefined: these ports and counters do not exist. The remaining behaviour is identical.

## Structure
- `fetch_pkg` contents:
  - `fetch_state_t` enum (FETCH, FAULT).
  - `fetch_entry_t` struct `{logic [31:0] instr; logic [31:0] pc;}`.
  - `PC_STEP = 4` constant.
- Sub-module `fetch_fifo` instances `fetch_entry_t`:
  - Generic `DEPTH`-entry synchronous FIFO.
  - Ports: `push`, `pop`, `flush`, `full`, `empty`, `head`.
  - Flush takes priority over push and pop.
- `fetch_unit` holds the PC register, the state machine and the push/redirect logic, plus the optional stats.

## Test plan
- Reset with `RESET_PC = 0`, memory preloaded, `out_ready = 1`: the `out_pc` sequence is 0, 4, 8, 12 on consecutive cycles starting 1 cycle after reset release, and `out_instruction` matches the memory words.
- Backpressure: hold `out_ready = 0` for 5 cycles from start.
  - The buffer fills with entries for PCs 0 and 4, and `read_address` holds at 8.
  - On release, the sequence is 0, 4, 8 with no gaps or duplicates.
- Redirect to `32'h40` while the buffer is full and `out_ready = 1`: the next cycle has `out_valid = 0`, and the cycle after has `out_pc = 32'h40`.
- Redirect to `32'h42`: `misaligned_fault = 1` and `out_valid = 0` from the next cycle, with `read_address` unchanged. A redirect to `32'h80` clears the fault, and `out_pc = 32'h80` 2 cycles later.
- PC wrap and mid-run reset:
  - Redirect to `32'hFFFF_FFFC`: the next head PCs are `FFFF_FFFC`, `0`.
  - Asserting `reset` while the buffer is full: the next cycle has `out_valid = 0` and `read_address = RESET_PC`.
- With `FETCH_STATS_EN`, 10 cycles at `out_ready = 1` followed by 1 redirect: `stat_fetched = 10` and `stat_flush = 1`.
